// File: rtl/multi_port_bram_arbiter.sv
// multi_port_bram_arbiter
//   Shares one true-dual-port block RAM between NUM_PORTS logical ports on a
//   single clock. Each cycle a rotating-priority scan grants up to two
//   requests. The first requester takes block port A and the next eligible
//   requester takes block port B. Read data returns to the issuing logical
//   port RD_LATENCY+2 cycles after the grant.
//
// Ports
//   clk_i, rst_i            clock (rising edge) and synchronous active-high reset
//   lp_req_i / lp_we_i      per-port request and write enable (0 = read)
//   lp_addr_i / lp_din_i    flattened per-port address and write data
//   lp_gnt_o                combinational grant; the request is accepted this cycle
//   lp_dout_o / lp_dvalid_o registered read data per port, plus a one-cycle valid pulse
//   block_port{a,b}_*       registered drive to the block RAM ports, and the
//                           read data coming back from the block RAM
module multi_port_bram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS-1:0]            lp_req_i,
  input  logic [NUM_PORTS-1:0]            lp_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] lp_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] lp_din_i,
  output logic [NUM_PORTS-1:0]            lp_gnt_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] lp_dout_o,
  output logic [NUM_PORTS-1:0]            lp_dvalid_o,
  output logic [ADDR_WIDTH-1:0]           block_porta_addr_o,
  output logic [DATA_WIDTH-1:0]           block_porta_din_o,
  output logic                            block_porta_en_o,
  output logic                            block_porta_we_o,
  input  logic [DATA_WIDTH-1:0]           block_porta_dout_i,
  output logic [ADDR_WIDTH-1:0]           block_portb_addr_o,
  output logic [DATA_WIDTH-1:0]           block_portb_din_o,
  output logic                            block_portb_en_o,
  output logic                            block_portb_we_o,
  input  logic [DATA_WIDTH-1:0]           block_portb_dout_i
);
  localparam int IDX_W = $clog2(NUM_PORTS);
  // One extra bit so that ptr + offset never overflows before the wrap.
  localparam int CW    = IDX_W + 1;

  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic                  a_found, b_found;
  logic [IDX_W-1:0]      a_idx, b_idx;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;
  logic [DATA_WIDTH-1:0] a_din, b_din;
  logic                  a_we, b_we;

  logic [ADDR_WIDTH-1:0] porta_addr_q, portb_addr_q;
  logic [DATA_WIDTH-1:0] porta_din_q, portb_din_q;
  logic                  porta_en_q, portb_en_q, porta_we_q, portb_we_q;

  // Read tags {valid, port}: stage 0 loads at issue, and the last stage lines up with block DOUT.
  logic                  tag_a_vld_q [RD_LATENCY+1];
  logic [IDX_W-1:0]      tag_a_idx_q [RD_LATENCY+1];
  logic                  tag_b_vld_q [RD_LATENCY+1];
  logic [IDX_W-1:0]      tag_b_idx_q [RD_LATENCY+1];

  logic [DATA_WIDTH-1:0] dout_q   [NUM_PORTS];
  logic                  dvalid_q [NUM_PORTS];

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_PORTS - 1)) ? '0 : i + 1'b1;
  endfunction

  // Rotating scan starting at ptr_q. A candidate for slot B is skipped if it
  // targets slot A's address and either operation writes. That rules out any
  // same-address collision inside the true-dual-port block.
  always_comb begin
    logic [CW-1:0]         cand;
    logic [IDX_W-1:0]      pi;
    logic [ADDR_WIDTH-1:0] addr_k;
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    a_addr  = '0;
    b_addr  = '0;
    a_din   = '0;
    b_din   = '0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    cand    = '0;
    pi      = '0;
    addr_k  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= CW'(NUM_PORTS)) cand = cand - CW'(NUM_PORTS);
      pi     = cand[IDX_W-1:0];
      addr_k = lp_addr_i[pi*ADDR_WIDTH +: ADDR_WIDTH];
      if (!rst_i && lp_req_i[pi]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = pi;
          a_addr  = addr_k;
          a_we    = lp_we_i[pi];
          a_din   = lp_din_i[pi*DATA_WIDTH +: DATA_WIDTH];
        end else if (!b_found && !(addr_k == a_addr && (a_we || lp_we_i[pi]))) begin
          b_found = 1'b1;
          b_idx   = pi;
          b_addr  = addr_k;
          b_we    = lp_we_i[pi];
          b_din   = lp_din_i[pi*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Slot B is always later in scan order than slot A. When B exists, it is
  // the last granted port and decides the next priority pointer.
  always_comb begin
    lp_gnt_o = '0;
    ptr_d    = ptr_q;
    if (a_found) begin
      lp_gnt_o[a_idx] = 1'b1;
      ptr_d           = wrap_inc(a_idx);
    end
    if (b_found) begin
      lp_gnt_o[b_idx] = 1'b1;
      ptr_d           = wrap_inc(b_idx);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      porta_en_q   <= 1'b0;
      porta_we_q   <= 1'b0;
      porta_addr_q <= '0;
      porta_din_q  <= '0;
      portb_en_q   <= 1'b0;
      portb_we_q   <= 1'b0;
      portb_addr_q <= '0;
      portb_din_q  <= '0;
      for (int s = 0; s <= RD_LATENCY; s++) begin
        tag_a_vld_q[s] <= 1'b0;
        tag_a_idx_q[s] <= '0;
        tag_b_vld_q[s] <= 1'b0;
        tag_b_idx_q[s] <= '0;
      end
    end else begin
      ptr_q          <= ptr_d;
      porta_en_q     <= a_found;
      porta_we_q     <= a_found & a_we;
      porta_addr_q   <= a_addr;
      porta_din_q    <= a_din;
      portb_en_q     <= b_found;
      portb_we_q     <= b_found & b_we;
      portb_addr_q   <= b_addr;
      portb_din_q    <= b_din;
      tag_a_vld_q[0] <= a_found & ~a_we;
      tag_a_idx_q[0] <= a_idx;
      tag_b_vld_q[0] <= b_found & ~b_we;
      tag_b_idx_q[0] <= b_idx;
      for (int s = 1; s <= RD_LATENCY; s++) begin
        tag_a_vld_q[s] <= tag_a_vld_q[s-1];
        tag_a_idx_q[s] <= tag_a_idx_q[s-1];
        tag_b_vld_q[s] <= tag_b_vld_q[s-1];
        tag_b_idx_q[s] <= tag_b_idx_q[s-1];
      end
    end
  end

  assign block_porta_en_o   = porta_en_q;
  assign block_porta_we_o   = porta_we_q;
  assign block_porta_addr_o = porta_addr_q;
  assign block_porta_din_o  = porta_din_q;
  assign block_portb_en_o   = portb_en_q;
  assign block_portb_we_o   = portb_we_q;
  assign block_portb_addr_o = portb_addr_q;
  assign block_portb_din_o  = portb_din_q;

  // A port holds at most one grant per cycle, so at most one of hit_a and
  // hit_b can be set for a given port.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ret
    logic hit_a, hit_b;
    assign hit_a = tag_a_vld_q[RD_LATENCY] && (tag_a_idx_q[RD_LATENCY] == IDX_W'(gi));
    assign hit_b = tag_b_vld_q[RD_LATENCY] && (tag_b_idx_q[RD_LATENCY] == IDX_W'(gi));

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        dout_q[gi]   <= '0;
        dvalid_q[gi] <= 1'b0;
      end else begin
        dvalid_q[gi] <= hit_a | hit_b;
        if (hit_a)      dout_q[gi] <= block_porta_dout_i;
        else if (hit_b) dout_q[gi] <= block_portb_dout_i;
      end
    end

    assign lp_dout_o[gi*DATA_WIDTH +: DATA_WIDTH] = dout_q[gi];
    assign lp_dvalid_o[gi]                         = dvalid_q[gi];
  end

endmodule
